// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN datapath stages: signed max, ReLU clamp,
// and a constant log2 for sizing counters.
package cnn_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  // The helpers work on a 64-bit signed carrier. Callers sign-extend into it
  // and truncate back, so any DATA_WIDTH up to 64 can share one definition.
  localparam int MAX_DW = 64;
  typedef logic signed [MAX_DW-1:0] wide_t;

  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic wide_t smax(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic wide_t relu(input wide_t a);
    return a[MAX_DW-1] ? '0 : a;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Partial-max line buffer: one entry per output column, combinational read,
// synchronous write, both addressed by the same window column.
module pool_line_buf #(
  parameter int DEPTH = 14,
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/stream_max_pool.sv
// Streaming POOL x POOL max-pool (stride POOL) over raster-order pixels, with a
// per-column partial-max buffer, optional fused ReLU and frame markers.
module stream_max_pool
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int POOL       = 2,
  parameter int RELU_EN    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         frame_done
);

  localparam int OUT_W = IMG_WIDTH / POOL;
  localparam int OUT_H = IMG_HEIGHT / POOL;
  localparam int CW    = clog2(IMG_WIDTH + 1);
  localparam int RW    = clog2(IMG_HEIGHT + 1);
  localparam int SW    = clog2(POOL);
  localparam int AW    = clog2(OUT_W);

  logic [CW-1:0]                r_col;
  logic [RW-1:0]                r_row;
  logic [SW-1:0]                r_sub_col;
  logic [SW-1:0]                r_sub_row;
  logic [AW-1:0]                r_win_col;
  logic signed [DATA_WIDTH-1:0] r_h_max;

  logic                         w_accept;
  logic                         w_in_win;
  logic                         w_row_end;
  logic                         w_frame_end;
  logic                         w_hv_done;
  logic                         w_emit;
  logic                         w_last;
  logic signed [DATA_WIDTH-1:0] w_h_next;
  logic signed [DATA_WIDTH-1:0] w_buf_rd;
  logic signed [DATA_WIDTH-1:0] w_v_next;
  logic signed [DATA_WIDTH-1:0] w_result;

  // Handshake: a beat moves on either side only when valid & ready are both high
  // at a rising edge; out_valid/out_data/out_last stay put until taken, and an
  // input is refused whenever a pending result could not be replaced.
  assign in_ready    = ~out_valid | out_ready;
  assign w_accept    = in_valid & in_ready;
  assign w_row_end   = (r_col == CW'(IMG_WIDTH - 1));
  assign w_frame_end = w_row_end & (r_row == RW'(IMG_HEIGHT - 1));
  assign w_in_win    = (r_col < CW'(OUT_W * POOL)) & (r_row < RW'(OUT_H * POOL));

  // h_max restarts on the first column of each window; the same value is the
  // completed horizontal maximum on the window's last column.
  assign w_h_next  = (r_sub_col == '0) ? in_data
                   : DATA_WIDTH'(smax(wide_t'(r_h_max), wide_t'(in_data)));
  assign w_hv_done = w_accept & w_in_win & (r_sub_col == SW'(POOL - 1));
  assign w_v_next  = (r_sub_row == '0) ? w_h_next
                   : DATA_WIDTH'(smax(wide_t'(w_buf_rd), wide_t'(w_h_next)));
  assign w_emit    = w_hv_done & (r_sub_row == SW'(POOL - 1));
  assign w_last    = (r_win_col == AW'(OUT_W - 1)) & (r_row == RW'(OUT_H * POOL - 1));
  assign w_result  = (RELU_EN != 0) ? DATA_WIDTH'(relu(wide_t'(w_v_next))) : w_v_next;

  pool_line_buf #(
    .DEPTH (OUT_W),
    .WIDTH (DATA_WIDTH),
    .AW    (AW)
  ) u_line_buf (
    .i_clk   (clk),
    .i_we    (w_hv_done),
    .i_addr  (r_win_col),
    .i_wdata (w_v_next),
    .o_rdata (w_buf_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_sub_col <= '0;
      r_sub_row <= '0;
      r_win_col <= '0;
      r_h_max   <= '0;
    end else if (w_accept) begin
      r_h_max <= w_h_next;
      if (w_row_end) begin
        r_col     <= '0;
        r_sub_col <= '0;
        r_win_col <= '0;
        if (w_frame_end) begin
          r_row     <= '0;
          r_sub_row <= '0;
        end else begin
          r_row     <= r_row + RW'(1);
          r_sub_row <= (r_sub_row == SW'(POOL - 1)) ? '0 : r_sub_row + SW'(1);
        end
      end else begin
        r_col <= r_col + CW'(1);
        if (r_sub_col == SW'(POOL - 1)) begin
          r_sub_col <= '0;
          // Saturate on the last window so trailing ignored columns stay in range.
          if (r_win_col != AW'(OUT_W - 1)) r_win_col <= r_win_col + AW'(1);
        end else begin
          r_sub_col <= r_sub_col + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_accept & w_frame_end;
      if (w_emit) begin
        out_valid <= 1'b1;
        out_data  <= w_result;
        out_last  <= w_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_max_pool.sv
// Bench for stream_max_pool: four parameterisations, table-driven frames,
// hand-written stall/abort sequences and randomized frames against a frame model.
module tb_stream_max_pool;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic               in_valid   [4];
  logic               in_ready   [4];
  logic signed [31:0] in_data    [4];
  logic               out_valid  [4];
  logic               out_ready  [4];
  logic signed [31:0] out_data   [4];
  logic               out_last   [4];
  logic               frame_done [4];

  stream_max_pool #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4), .POOL(2), .RELU_EN(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .frame_done(frame_done[0]));
  stream_max_pool #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4), .POOL(2), .RELU_EN(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1]), .frame_done(frame_done[1]));
  stream_max_pool #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5), .POOL(2), .RELU_EN(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_last(out_last[2]), .frame_done(frame_done[2]));
  stream_max_pool #(.DATA_WIDTH(32), .IMG_WIDTH(6), .IMG_HEIGHT(6), .POOL(3), .RELU_EN(1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
    .out_last(out_last[3]), .frame_done(frame_done[3]));

  function automatic int g_w(input int k);
    case (k)
      2: return 5;
      3: return 6;
      default: return 4;
    endcase
  endfunction
  function automatic int g_p(input int k);
    return (k == 3) ? 3 : 2;
  endfunction
  function automatic int g_r(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  // ---------------- scoreboard / model state ----------------
  int                 n_err;
  int                 n_checks;
  logic [32:0]        exp_q[$];
  int                 m_pix [64];
  int                 m_idx;
  bit                 use_model;
  bit                 fd_exp;
  bit                 emit_prev;
  bit                 last_accept;
  bit                 held_valid;
  logic signed [31:0] held_data;
  logic               held_last;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: keep the whole frame, compute each window's max when its last
  // pixel arrives.
  task automatic model_accept(input int k, input logic signed [31:0] d);
    int w, p, ow, oh, r, c, mx;
    logic last;
    w = g_w(k); p = g_p(k); ow = w / p; oh = w / p;
    r = m_idx / w; c = m_idx % w;
    m_pix[m_idx] = d;
    fd_exp = (m_idx == w * w - 1);
    if (r < oh * p && c < ow * p && (r % p) == p - 1 && (c % p) == p - 1) begin
      mx = m_pix[(r - p + 1) * w + (c - p + 1)];
      for (int dr = 0; dr < p; dr++)
        for (int dc = 0; dc < p; dc++)
          if (m_pix[(r - dr) * w + (c - dc)] > mx) mx = m_pix[(r - dr) * w + (c - dc)];
      if (g_r(k) != 0 && mx < 0) mx = 0;
      last = (c / p == ow - 1) && (r / p == oh - 1);
      emit_prev = 1'b1;
      if (use_model) exp_q.push_back({last, 32'(mx)});
    end
    m_idx = (m_idx + 1) % (w * w);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int k, input logic v, input logic signed [31:0] d, input logic ordy);
    logic [32:0] e;
    @(negedge clk);
    in_valid[k]  = v;
    in_data[k]   = d;
    out_ready[k] = ordy;
    #1;
    chk("frame_done", frame_done[k], fd_exp);
    if (emit_prev) chk("latency_valid", out_valid[k], 1);
    if (held_valid) begin
      chk("hold_valid", out_valid[k], 1);
      chk("hold_data", out_data[k], held_data);
      chk("hold_last", out_last[k], held_last);
    end
    chk("in_ready", in_ready[k], !out_valid[k] || ordy);
    if (out_valid[k] && ordy) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_output: got %0d required no result at %0t", out_data[k], $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data[k], $signed(e[31:0]));
        chk("out_last", out_last[k], e[32]);
      end
    end
    held_valid  = out_valid[k] && !ordy;
    held_data   = out_data[k];
    held_last   = out_last[k];
    last_accept = v && in_ready[k];
    emit_prev   = 1'b0;
    fd_exp      = 1'b0;
    if (last_accept) model_accept(k, d);
  endtask

  task automatic feed_pixel(input int k, input logic signed [31:0] d, input bit rnd);
    int guard;
    logic v, r;
    guard = 0;
    do begin
      v = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(k, v, d, r);
      guard++;
    end while (!last_accept && guard < 64);
    if (!last_accept) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout: got no acceptance required one within 64 cycles");
    end
  endtask

  task automatic drain(input int k);
    repeat (8) step(k, 1'b0, '0, 1'b1);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_empty: got %0d results outstanding required 0", exp_q.size());
    end
  endtask

  task automatic do_reset(input int k);
    @(negedge clk);
    rst = 1'b1;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    #1;
    chk("rst_out_valid", out_valid[k], 0);
    chk("rst_out_data", out_data[k], 0);
    chk("rst_out_last", out_last[k], 0);
    chk("rst_frame_done", frame_done[k], 0);
    chk("rst_in_ready", in_ready[k], 1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_idx = 0; fd_exp = 0; emit_prev = 0; held_valid = 0;
  endtask

  task automatic push4(input int e0, input int e1, input int e2, input int e3);
    exp_q.push_back({1'b0, 32'(e0)});
    exp_q.push_back({1'b0, 32'(e1)});
    exp_q.push_back({1'b0, 32'(e2)});
    exp_q.push_back({1'b1, 32'(e3)});
  endtask

  function automatic logic signed [31:0] tbl_px(input int kind, input int val, input int p);
    case (kind)
      0: return p;
      1: return val;
      default: return (p == 5) ? -2 : -7;
    endcase
  endfunction

  function automatic logic signed [31:0] rnd_px();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return 32'sh8000_0000;
      1: return 32'sh7fff_ffff;
      2: return $urandom;
      default: return int'($urandom_range(0, 200)) - 100;
    endcase
  endfunction

  typedef struct {
    int inst;   // which parameterisation
    int kind;   // 0 ramp, 1 constant, 2 all -7 with -2 at (1,1)
    int val;
    int e0, e1, e2, e3;
    bit chain;  // next frame follows with no gap
  } vec_t;

  vec_t vecs [6];

  // ---------------- test ----------------
  initial begin
    int cur, n, cut;
    n_err = 0; n_checks = 0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1;
    end
    use_model = 0; m_idx = 0; fd_exp = 0; emit_prev = 0; held_valid = 0; last_accept = 0;

    vecs[0] = '{0, 0, 0,   5,   7,  13,  15, 1'b0};
    vecs[1] = '{0, 2, 0,   0,   0,   0,   0, 1'b0};
    vecs[2] = '{1, 2, 0,  -2,  -7,  -7,  -7, 1'b0};
    vecs[3] = '{2, 0, 0,   6,   8,  16,  18, 1'b0};
    vecs[4] = '{3, 0, 0,  14,  17,  32,  35, 1'b1};
    vecs[5] = '{3, 1, 100, 100, 100, 100, 100, 1'b0};

    do_reset(0);
    cur = 0;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].inst != cur) begin
        cur = vecs[i].inst;
        do_reset(cur);
      end
      use_model = 0;
      push4(vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
      n = g_w(cur) * g_w(cur);
      for (int p = 0; p < n; p++) feed_pixel(cur, tbl_px(vecs[i].kind, vecs[i].val, p), 1'b0);
      if (!vecs[i].chain) drain(cur);
    end

    // Backpressure on the first result of a 4x4 ramp.
    do_reset(0);
    use_model = 0;
    push4(5, 7, 13, 15);
    for (int p = 0; p < 6; p++) feed_pixel(0, p, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b1, 6, 1'b0);
      chk("stall_in_ready", in_ready[0], 0);
      chk("stall_data", out_data[0], 5);
    end
    for (int p = 6; p < 16; p++) feed_pixel(0, p, 1'b0);
    drain(0);

    // Abort a frame after 9 pixels, then a clean frame.
    do_reset(0);
    use_model = 1;
    for (int p = 0; p < 9; p++) feed_pixel(0, p, 1'b0);
    do_reset(0);
    use_model = 0;
    push4(5, 7, 13, 15);
    for (int p = 0; p < 16; p++) feed_pixel(0, p, 1'b0);
    drain(0);

    // Randomized frames with random valid/ready against the frame model.
    for (int k = 0; k < 4; k++) begin
      do_reset(k);
      use_model = 1;
      n = g_w(k) * g_w(k);
      for (int f = 0; f < 3; f++)
        for (int p = 0; p < n; p++) feed_pixel(k, rnd_px(), 1'b1);
      cut = $urandom_range(1, n - 1);
      for (int p = 0; p < cut; p++) feed_pixel(k, rnd_px(), 1'b1);
      do_reset(k);
      for (int p = 0; p < n; p++) feed_pixel(k, rnd_px(), 1'b1);
      drain(k);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    n_checks++; n_err++;
    $display("FAIL watchdog: got timeout required completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
